hmc_mem_init_responder: RTL
===========================

HMC_MEM_INIT_RESPONDER -- requirements
Module: hmc_mem_init_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 128: data width of each link data bus.
REQ-002 SHALL have parameter NUM_LANES, default 8: lane count; DWIDTH/NUM_LANES bits per lane.
REQ-003 SHALL have parameter T_INIT_CYC, default 1000: clk_hmc cycles from P_RST_N rise until the device is ready for LXRXPS.
REQ-004 SHALL have parameter T_RESP1_CYC, default 1000: cycles from LXRXPS rise until LXTXPS rise.
REQ-005 SHALL have parameter T_RESP2_CYC, default 1000: cycles from LXRXPS fall until LXTXPS fall.
REQ-006 SHALL have parameter NULL_DET, default 16: consecutive all-zero host words needed to leave training.
REQ-007 SHALL have parameter TS1_LANE_WORD, default 16'hF0C3: per-lane training word.
REQ-008 SHALL have parameter TRAIN_TIMEOUT, default 65535: training timeout in cycles.
REQ-009 SHALL have ports clk_hmc, input, 1 bit: the single clock; all logic on the rising edge.
REQ-010 SHALL have port res_hmc, input, 1 bit: reset, synchronous, active-high.
REQ-011 SHALL have port P_RST_N, input, 1 bit: host reset to the device, active-low.
REQ-012 SHALL have port LXRXPS, input, 1 bit: host power-state request.
REQ-013 SHALL have port LXTXPS, output, 1 bit: device power-state response.
REQ-014 SHALL have port FERR_N, output, 1 bit: fatal error, active-low.
REQ-015 SHALL have port dev_data_rx, input, DWIDTH bits: words from the host transmitter.
REQ-016 SHALL have port dev_data_tx, output, DWIDTH bits: words to the host receiver.
REQ-017 SHALL have port link_active, output, 1 bit: high in ACTIVE only.
REQ-018 SHALL have port dev_state, output, 3 bits: FSM state encoding, for debug.

Function
REQ-019 FSM states SHALL be RST=0, INIT=1, WAIT_RXPS=2, RESP1=3, TRAIN=4, ACTIVE=5, SLEEP_WAIT=6, SLEEP=7.
REQ-020 P_RST_N sampled low in any state SHALL force RST on the next edge; this has priority over every other transition.
REQ-021 RST SHALL go to INIT on the first edge where P_RST_N is sampled high.
REQ-022 INIT SHALL last exactly T_INIT_CYC cycles, then go to WAIT_RXPS; an LXRXPS change during INIT SHALL be ignored.
REQ-023 WAIT_RXPS SHALL go to RESP1 when LXRXPS is sampled high.
REQ-024 RESP1 SHALL last T_RESP1_CYC cycles, then go to TRAIN; LXTXPS SHALL rise on that same edge.
REQ-025 In TRAIN, dev_data_tx SHALL be TS1_LANE_WORD replicated NUM_LANES times.
REQ-026 TRAIN SHALL count consecutive cycles with dev_data_rx == 0; a nonzero word SHALL reset the count; the count reaching NULL_DET SHALL move to ACTIVE.
REQ-027 In ACTIVE, dev_data_tx SHALL be all-zero (NULL), link_active SHALL be 1, and LXRXPS low SHALL move to SLEEP_WAIT.
REQ-028 SLEEP_WAIT SHALL last T_RESP2_CYC cycles, then go to SLEEP with LXTXPS falling on that edge; LXRXPS rising during SLEEP_WAIT SHALL return to ACTIVE with LXTXPS still high.
REQ-029 SLEEP SHALL drive dev_data_tx = 0 and go to RESP1 when LXRXPS is sampled high.
REQ-030 Each timer SHALL reload on state entry; a timer length of 0 SHALL be treated as 1 cycle.
REQ-031 All outputs SHALL be registered; outside TRAIN, dev_data_tx SHALL be 0.

Reset
REQ-032 res_hmc high SHALL force state RST, LXTXPS=0, FERR_N=1, dev_data_tx=0, link_active=0, dev_state=0, and clear all counters; res_hmc SHALL take priority over P_RST_N.

Configuration
REQ-033 Macro HMC_MEM_FERR_TIMEOUT_EN defined SHALL add a counter in TRAIN: reaching TRAIN_TIMEOUT cycles without exiting SHALL drive FERR_N=0, LXTXPS=0 and hold dev_data_tx=0 in RST-encoded idle until P_RST_N low or res_hmc.
REQ-034 Macro HMC_MEM_FERR_TIMEOUT_EN undefined SHALL tie FERR_N to 1 and let TRAIN wait indefinitely.

Verification
REQ-035 Bench parameters SHALL be T_INIT_CYC=50, T_RESP1_CYC=20, T_RESP2_CYC=10, NULL_DET=16, TRAIN_TIMEOUT=1000.
REQ-036 Power-up: P_RST_N rises, LXRXPS high at cycle 60 -> LXTXPS rises exactly 20 cycles later and dev_data_tx = 128'hF0C3 repeated.
REQ-037 Training exit: 15 zero words, then 1 nonzero word, then 16 zero words -> ACTIVE only after the 16th zero of the second run; link_active=1.
REQ-038 Sleep: LXRXPS drops in ACTIVE -> LXTXPS falls after 10 cycles; LXRXPS back high at cycle 5 of the wait -> stays ACTIVE.
REQ-039 Mid-operation reset: P_RST_N low during TRAIN -> next edge dev_state=0, LXTXPS=0, dev_data_tx=0.
REQ-040 Timeout (macro defined): host holds TS1 for 1000 cycles -> FERR_N=0; P_RST_N pulse low -> FERR_N=1.

Source files
------------

// File: rtl/hmc_mem_init_responder.sv
// hmc_mem_init_responder: device-side model of the HMC link power-up handshake.
// Sequence: reset -> init delay -> wait for LXRXPS -> respond (LXTXPS) ->
// TS1 training until a run of NULL words -> active, with a sleep/wake cycle.
// Optional build macro HMC_MEM_FERR_TIMEOUT_EN adds a training watchdog that
// drives FERR_N low and parks the FSM in RST until P_RST_N is pulsed low.
module hmc_mem_init_responder #(
    parameter int          DWIDTH        = 128,
    parameter int          NUM_LANES     = 8,
    parameter int          T_INIT_CYC    = 1000,
    parameter int          T_RESP1_CYC   = 1000,
    parameter int          T_RESP2_CYC   = 1000,
    parameter int          NULL_DET      = 16,
    parameter logic [15:0] TS1_LANE_WORD = 16'hF0C3,
    parameter int          TRAIN_TIMEOUT = 65535
) (
    input  logic              clk_hmc,
    input  logic              res_hmc,
    input  logic              P_RST_N,
    input  logic              LXRXPS,
    output logic              LXTXPS,
    output logic              FERR_N,
    input  logic [DWIDTH-1:0] dev_data_rx,
    output logic [DWIDTH-1:0] dev_data_tx,
    output logic              link_active,
    output logic [2:0]        dev_state
);

    localparam int LANE_W = DWIDTH / NUM_LANES;

    // Timers count down from length-1; a zero length behaves as one cycle.
    localparam logic [31:0] INIT_LD  = (T_INIT_CYC  > 0) ? 32'(T_INIT_CYC  - 1) : 32'd0;
    localparam logic [31:0] RESP1_LD = (T_RESP1_CYC > 0) ? 32'(T_RESP1_CYC - 1) : 32'd0;
    localparam logic [31:0] RESP2_LD = (T_RESP2_CYC > 0) ? 32'(T_RESP2_CYC - 1) : 32'd0;
    localparam logic [31:0] NULL_LAST = (NULL_DET > 0) ? 32'(NULL_DET - 1) : 32'd0;

    typedef enum logic [2:0] {
        RST        = 3'd0,
        INIT       = 3'd1,
        WAIT_RXPS  = 3'd2,
        RESP1      = 3'd3,
        TRAIN      = 3'd4,
        ACTIVE     = 3'd5,
        SLEEP_WAIT = 3'd6,
        SLEEP      = 3'd7
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       timer, timer_ld;
    logic [31:0]       null_cnt;
    logic              timer_done;
    logic              rx_zero;
    logic              ferr;
    logic [DWIDTH-1:0] ts1_word;

    assign timer_done = (timer == 32'd0);
    assign rx_zero    = (dev_data_rx == '0);
    assign dev_state  = state;

    // Training pattern: the lane word replicated across every lane.
    always_comb begin
        ts1_word = '0;
        for (int i = 0; i < NUM_LANES; i++)
            ts1_word[i*LANE_W +: LANE_W] = LANE_W'(TS1_LANE_WORD);
    end

`ifdef HMC_MEM_FERR_TIMEOUT_EN
    localparam logic [31:0] TO_LD = (TRAIN_TIMEOUT > 0) ? 32'(TRAIN_TIMEOUT - 1) : 32'd0;
    logic [31:0] to_cnt;
    logic        ferr_nxt;

    // Watchdog: reloads on TRAIN entry, counts down while training.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc)
            to_cnt <= '0;
        else if (state_nxt == TRAIN && state != TRAIN)
            to_cnt <= TO_LD;
        else if (to_cnt != 32'd0)
            to_cnt <= to_cnt - 32'd1;
    end

    // Fatal flag: set on watchdog expiry, cleared only by P_RST_N low or reset.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            ferr   <= 1'b0;
            FERR_N <= 1'b1;
        end else begin
            ferr   <= ferr_nxt;
            FERR_N <= ~ferr_nxt;
        end
    end
`else
    assign ferr   = 1'b0;
    assign FERR_N = 1'b1;
`endif

    // Next-state logic; host reset overrides every other transition.
    always_comb begin
        state_nxt = state;
`ifdef HMC_MEM_FERR_TIMEOUT_EN
        ferr_nxt  = ferr;
`endif
        if (!P_RST_N) begin
            state_nxt = RST;
`ifdef HMC_MEM_FERR_TIMEOUT_EN
            ferr_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                RST:        if (!ferr) state_nxt = INIT;
                INIT:       if (timer_done) state_nxt = WAIT_RXPS;
                WAIT_RXPS:  if (LXRXPS) state_nxt = RESP1;
                RESP1:      if (timer_done) state_nxt = TRAIN;
                TRAIN: begin
                    if (rx_zero && null_cnt >= NULL_LAST)
                        state_nxt = ACTIVE;
`ifdef HMC_MEM_FERR_TIMEOUT_EN
                    else if (to_cnt == 32'd0) begin
                        state_nxt = RST;
                        ferr_nxt  = 1'b1;
                    end
`endif
                end
                ACTIVE:     if (!LXRXPS) state_nxt = SLEEP_WAIT;
                SLEEP_WAIT: begin
                    if (LXRXPS)          state_nxt = ACTIVE;
                    else if (timer_done) state_nxt = SLEEP;
                end
                SLEEP:      if (LXRXPS) state_nxt = RESP1;
                default:    state_nxt = RST;
            endcase
        end
    end

    // Reload value for the shared phase timer, chosen by the state being entered.
    always_comb begin
        timer_ld = 32'd0;
        case (state_nxt)
            INIT:       timer_ld = INIT_LD;
            RESP1:      timer_ld = RESP1_LD;
            SLEEP_WAIT: timer_ld = RESP2_LD;
            default:    timer_ld = 32'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc) state <= RST;
        else         state <= state_nxt;
    end

    // Phase timer reloads on any state change, then counts down to zero.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc)
            timer <= '0;
        else if (state_nxt != state)
            timer <= timer_ld;
        else if (!timer_done)
            timer <= timer - 32'd1;
    end

    // Consecutive-NULL counter; any nonzero word or leaving TRAIN clears it.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc)
            null_cnt <= '0;
        else if (state == TRAIN && state_nxt == TRAIN && rx_zero)
            null_cnt <= null_cnt + 32'd1;
        else
            null_cnt <= '0;
    end

    // Registered outputs, decoded from the state being entered so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            LXTXPS      <= 1'b0;
            dev_data_tx <= '0;
            link_active <= 1'b0;
        end else begin
            LXTXPS      <= (state_nxt == TRAIN) || (state_nxt == ACTIVE) ||
                           (state_nxt == SLEEP_WAIT);
            dev_data_tx <= (state_nxt == TRAIN) ? ts1_word : '0;
            link_active <= (state_nxt == ACTIVE);
        end
    end

endmodule
